// File: rtl/perf_capture.sv
// perf_capture: measures accelerator run latency from an upstream free-running
// cycle counter, queues each result in a small FIFO and keeps run/drop counts.
// Optional feature: define PERF_MINMAX_EN to track min/max latency statistics;
// without it min_lat and max_lat are tied to zero.
module perf_capture #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      counter,
  input  logic             run_start,
  input  logic             run_done,
  input  logic             clear,
  output logic             cnt_en,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LAT_W-1:0] res_data,
  output logic [15:0]      run_count,
  output logic [7:0]       drop_count,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [63:0]      ts_reg;
  logic [63:0]      delta;
  logic [LAT_W-1:0] lat;
  logic             complete;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             full;
  logic             empty;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [LAT_W-1:0] mem [DEPTH];

  // The upstream counter runs whenever this block is out of reset.
  assign cnt_en = ~rst;
  assign busy   = (state == RUN);

  // A run completes on run_done while running; clear overrides everything.
  assign complete = (state == RUN) && run_done && !clear;

  // Modulo-2^64 subtraction keeps the delta correct across counter wrap.
  assign delta = counter - ts_reg;

  // Latencies that do not fit in LAT_W bits saturate to all-ones.
  generate
    if (LAT_W == 64) begin : g_full
      assign lat = delta;
    end else begin : g_sat
      assign lat = (|delta[63:LAT_W]) ? '1 : delta[LAT_W-1:0];
    end
  endgenerate

  // FIFO status: the extra pointer bit separates full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign push_ok   = complete && (!full || pop);
  assign drop      = complete && full && !pop;
  assign res_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Next-state logic: run_start always (re)enters RUN, a lone run_done leaves it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_start) state_nxt = RUN;
      RUN:     if (run_done && !run_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // State register and run start timestamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ts_reg <= '0;
    end else begin
      state <= state_nxt;
      if (clear) ts_reg <= '0;
      else if (run_start) ts_reg <= counter;
    end
  end

  // FIFO pointers; a push into a full FIFO is allowed only alongside a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage needs no reset; empty entries are masked at the output.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= lat;
  end

  // Completed-run counter wraps, drop counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_count  <= '0;
      drop_count <= '0;
    end else if (clear) begin
      run_count  <= '0;
      drop_count <= '0;
    end else begin
      if (complete) run_count <= run_count + 16'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

`ifdef PERF_MINMAX_EN
  // Min/max track every completion, including results that were dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_lat <= '1;
      max_lat <= '0;
    end else if (clear) begin
      min_lat <= '1;
      max_lat <= '0;
    end else if (complete) begin
      if (lat < min_lat) min_lat <= lat;
      if (lat > max_lat) max_lat <= lat;
    end
  end
`else
  assign min_lat = '0;
  assign max_lat = '0;
`endif

endmodule

// File: tb/tb_perf_capture.sv
// tb_perf_capture: directed and randomized checks of perf_capture against a
// queue-based reference model of the latency capture behaviour.
module tb_perf_capture;

  localparam int DEPTH = 8;
  localparam int LAT_W = 32;
  localparam longint unsigned SAT = (64'd1 << LAT_W) - 64'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      counter;
  logic             run_start;
  logic             run_done;
  logic             clear;
  logic             cnt_en;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [LAT_W-1:0] res_data;
  logic [15:0]      run_count;
  logic [7:0]       drop_count;
  logic [LAT_W-1:0] min_lat;
  logic [LAT_W-1:0] max_lat;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model state
  bit              m_run   = 1'b0;
  longint unsigned m_ts    = 0;
  longint unsigned m_q[$];
  int              m_runs  = 0;
  int              m_drops = 0;
  longint unsigned m_min   = SAT;
  longint unsigned m_max   = 0;
  bit              m_fin;
  bit              m_pop;
  longint unsigned m_d;
  longint unsigned m_l;
  longint unsigned exp_min;
  longint unsigned exp_max;

  perf_capture #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .counter    (counter),
    .run_start  (run_start),
    .run_done   (run_done),
    .clear      (clear),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .run_count  (run_count),
    .drop_count (drop_count),
    .min_lat    (min_lat),
    .max_lat    (max_lat)
  );

  always #5 clk = ~clk;

  // Behavioural model: a run measures counter difference, results queue up to DEPTH.
  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      m_run   = 1'b0;
      m_ts    = 0;
      m_q.delete();
      m_runs  = 0;
      m_drops = 0;
      m_min   = SAT;
      m_max   = 0;
    end else begin
      m_pop = (m_q.size() != 0) && res_ready;
      m_fin = m_run && run_done;
      m_l   = 0;
      if (m_fin) begin
        m_d    = counter - m_ts;
        m_l    = (m_d > SAT) ? SAT : m_d;
        m_runs = (m_runs + 1) % 65536;
        if (m_l < m_min) m_min = m_l;
        if (m_l > m_max) m_max = m_l;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_fin) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_l);
        else if (m_drops < 255) m_drops++;
      end
      if (run_start) begin
        m_run = 1'b1;
        m_ts  = counter;
      end else if (m_fin) begin
        m_run = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
`ifdef PERF_MINMAX_EN
    exp_min = m_min;
    exp_max = m_max;
`else
    exp_min = 0;
    exp_max = 0;
`endif
    checkOutput({tag, ".cnt_en"},     64'(cnt_en),     64'(!rst));
    checkOutput({tag, ".busy"},       64'(busy),       64'(m_run));
    checkOutput({tag, ".res_valid"},  64'(res_valid),  64'(m_q.size() != 0));
    checkOutput({tag, ".res_data"},   64'(res_data),   (m_q.size() != 0) ? m_q[0] : 64'd0);
    checkOutput({tag, ".run_count"},  64'(run_count),  64'(m_runs));
    checkOutput({tag, ".drop_count"}, 64'(drop_count), 64'(m_drops));
    checkOutput({tag, ".min_lat"},    64'(min_lat),    exp_min);
    checkOutput({tag, ".max_lat"},    64'(max_lat),    exp_max);
  endtask

  // One clock: drive inputs, let the edge happen, check at the falling edge.
  task automatic applyStimulus(input logic s, input logic d, input logic r, input logic c, input string tag);
    run_start = s;
    run_done  = d;
    res_ready = r;
    clear     = c;
    @(posedge clk);
    @(negedge clk);
    run_start = 1'b0;
    run_done  = 1'b0;
    res_ready = 1'b0;
    clear     = 1'b0;
    checkModel(tag);
    counter = counter + 64'd1;
  endtask

  task automatic doRun(input int lat, input logic ready_at_done, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, {tag, ".start"});
    repeat (lat - 1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, {tag, ".wait"});
    applyStimulus(1'b0, 1'b1, ready_at_done, 1'b0, {tag, ".done"});
  endtask

  initial begin
    counter   = 64'd0;
    run_start = 1'b0;
    run_done  = 1'b0;
    clear     = 1'b0;
    res_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkModel("reset");
    checkOutput("reset.cnt_en", 64'(cnt_en), 64'd0);
    checkOutput("reset.res_data", 64'(res_data), 64'd0);
`ifdef PERF_MINMAX_EN
    checkOutput("reset.min_lat", 64'(min_lat), SAT);
`else
    checkOutput("reset.min_lat", 64'(min_lat), 64'd0);
`endif
    rst = 1'b0;

    // Basic run: 100 -> 350
    counter = 64'd100;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "basic.start");
    checkOutput("basic.busy1", 64'(busy), 64'd1);
    while (counter != 64'd350) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "basic.wait");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "basic.done");
    checkOutput("basic.data", 64'(res_data), 64'd250);
    checkOutput("basic.valid", 64'(res_valid), 64'd1);
    checkOutput("basic.runs", 64'(run_count), 64'd1);
    checkOutput("basic.busy0", 64'(busy), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "basic.pop");
    checkOutput("basic.empty", 64'(res_valid), 64'd0);

    // Counter wrap
    counter = 64'hFFFF_FFFF_FFFF_FFF6;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "wrap.start");
    counter = 64'd5;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "wrap.done");
    checkOutput("wrap.data", 64'(res_data), 64'd15);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "wrap.pop");

    // Saturation boundary: 2^LAT_W - 2 fits, 2^LAT_W + 5 saturates
    counter = 64'd1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "sat.start1");
    counter = 64'd1000 + SAT - 64'd1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "sat.done1");
    checkOutput("sat.fit", 64'(res_data), SAT - 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "sat.start2");
    counter = counter + SAT + 64'd5;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "sat.done2");
    checkOutput("sat.over", 64'(res_data), SAT);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "sat.pop");

    // run_done in IDLE is ignored; start+done in IDLE acts as start
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "idle.done");
    checkOutput("idle.runs", 64'(run_count), 64'd4);
    checkOutput("idle.valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "idle.both");
    checkOutput("idle.both.busy", 64'(busy), 64'd1);
    checkOutput("idle.both.runs", 64'(run_count), 64'd4);

    // Restart in RUN, then start+done in RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "restart.start");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "restart.wait");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "restart.done");
    checkOutput("restart.data", 64'(res_data), 64'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "both.start");
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "both.wait");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "both.edge");
    checkOutput("both.busy", 64'(busy), 64'd1);
    checkOutput("both.runs", 64'(run_count), 64'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "both.wait2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "both.done");
    checkOutput("both.runs2", 64'(run_count), 64'd7);

    // Clear mid-RUN with 3 entries held
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clr.start");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "clr.clear");
    checkOutput("clr.valid", 64'(res_valid), 64'd0);
    checkOutput("clr.busy", 64'(busy), 64'd0);
    checkOutput("clr.runs", 64'(run_count), 64'd0);

    // Fill FIFO: 10 runs, no pops
    for (int i = 0; i < 10; i++) doRun(i + 1, 1'b0, "fill");
    checkOutput("fill.drops", 64'(drop_count), 64'd2);
    checkOutput("fill.runs", 64'(run_count), 64'd10);
    checkOutput("fill.head", 64'(res_data), 64'd1);
    doRun(5, 1'b1, "fullpop");
    checkOutput("fullpop.drops", 64'(drop_count), 64'd2);
    checkOutput("fullpop.runs", 64'(run_count), 64'd11);
    checkOutput("fullpop.head", 64'(res_data), 64'd2);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "drain");
    checkOutput("drain.valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "stats.clear");

    // Min/max statistics
    doRun(40, 1'b1, "mm40");
    doRun(10, 1'b1, "mm10");
    doRun(70, 1'b1, "mm70");
`ifdef PERF_MINMAX_EN
    checkOutput("mm.min", 64'(min_lat), 64'd10);
    checkOutput("mm.max", 64'(max_lat), 64'd70);
`else
    checkOutput("mm.min", 64'(min_lat), 64'd0);
    checkOutput("mm.max", 64'(max_lat), 64'd0);
`endif

    // Reset mid-RUN discards the run
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "rstrun.start");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "rstrun.wait");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkModel("rstrun.inreset");
    checkOutput("rstrun.busy", 64'(busy), 64'd0);
    checkOutput("rstrun.cnt_en", 64'(cnt_en), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "rstrun.done");
    checkOutput("rstrun.valid", 64'(res_valid), 64'd0);
    checkOutput("rstrun.runs", 64'(run_count), 64'd0);
    doRun(7, 1'b0, "rstrun.after");
    checkOutput("rstrun.after.data", 64'(res_data), 64'd7);
    checkOutput("rstrun.after.runs", 64'(run_count), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) counter = {$urandom, $urandom};
      applyStimulus($urandom_range(3) == 0, $urandom_range(2) == 0,
                    $urandom_range(3) == 0, $urandom_range(99) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/perf_capture.md
PERF_CAPTURE -- requirements
Module: perf_capture

Interface
REQ-001 Parameter DEPTH, default 8: result FIFO entries; power of two, 2..64.
REQ-002 Parameter LAT_W, default 32: stored latency width, 8..64.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 counter  in  64  free-running cycle count from the upstream cycle counter.
REQ-006 run_start  in  1  single-cycle pulse: accelerator run begins.
REQ-007 run_done  in  1  single-cycle pulse: accelerator run ends.
REQ-008 clear  in  1  synchronous clear of FIFO, statistics and FSM.
REQ-009 cnt_en  out  1  drives upstream counter start; 1 whenever not in reset.
REQ-010 busy  out  1  1 while in state RUN.
REQ-011 res_valid  out  1  FIFO non-empty.
REQ-012 res_ready  in  1  consumer pop; pop occurs when res_valid && res_ready.
REQ-013 res_data  out  LAT_W  head-of-FIFO latency; stable while res_valid && !res_ready.
REQ-014 run_count  out  16  completed runs, wraps modulo 2^16.
REQ-015 drop_count  out  8  results lost to full FIFO, saturates at 255.
REQ-016 min_lat, max_lat  out  LAT_W each  latency statistics (see Configuration).

Function
REQ-017 FSM states IDLE, RUN; IDLE->RUN on run_start, latching counter into 64-bit ts_reg.
REQ-018 In IDLE, run_done is ignored: no push, no count change.
REQ-019 In RUN, run_done: delta = counter - ts_reg, modulo 2^64, so counter wrap yields the correct delta; return to IDLE.
REQ-020 Stored latency = delta if delta < 2^LAT_W, else all-ones (saturate).
REQ-021 In RUN, run_start without run_done: re-latch ts_reg (restart); no push.
REQ-022 In RUN, run_start and run_done in the same cycle: complete the current run per REQ-019, then stay in RUN with ts_reg = current counter.
REQ-023 In IDLE, run_start and run_done in the same cycle: treat as run_start only.
REQ-024 Each completion increments run_count, whether or not the result is stored.
REQ-025 Completion at cycle t pushes the result; res_valid is 1 from cycle t+1 (1-cycle latency).
REQ-026 Push when FIFO full and no pop in the same cycle: result dropped, drop_count += 1 (saturating).
REQ-027 Push and pop in the same cycle: both occur, including when full; occupancy unchanged.
REQ-028 Pop when empty: no effect.
REQ-029 Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-030 clear has priority over all events in that cycle: FIFO empty, run_count = drop_count = 0, statistics at reset values, FSM to IDLE.

Reset
REQ-031 rst asserted: state IDLE, ts_reg = 0, FIFO empty, res_valid = 0, res_data = 0, busy = 0.
REQ-032 rst asserted: run_count = 0, drop_count = 0, min_lat = all-ones, max_lat = 0, cnt_en = 0.
REQ-033 Reset mid-run discards the run in progress; first run_start after release behaves as from IDLE.

Configuration
REQ-034 Macro PERF_MINMAX_EN defined: each completion updates min_lat = min(min_lat, latency) and max_lat = max(max_lat, latency), including dropped results.
REQ-035 PERF_MINMAX_EN undefined: no comparator logic; min_lat and max_lat are tied to 0.

Verification
REQ-036 run_start at counter=100, run_done at counter=350 -> res_data=250, res_valid next cycle, run_count=1, busy 1 then 0.
REQ-037 run_start at counter=2^64-10, run_done at counter=5 -> res_data=15.
REQ-038 LAT_W=8: run of 300 cycles -> res_data=255.
REQ-039 DEPTH=8, 10 runs, res_ready=0 -> 8 entries held, drop_count=2, run_count=10; 9th run done together with a pop -> no drop for that run.
REQ-040 Runs of 40, 10 and 70 cycles with PERF_MINMAX_EN -> min_lat=10, max_lat=70; without the macro both read 0.
REQ-041 rst asserted mid-RUN, then run_done -> no push, run_count=0; clear mid-RUN with 3 entries -> res_valid=0, FSM IDLE.
